// File: rtl/alarm_beep_ctrl_if.sv
// Signal bundle between the alarm controller and its surroundings: alarm
// matches, enables, user buttons and the per-channel beep/status outputs.
interface alarm_beep_ctrl_if;
  logic       tick_1s;
  logic [4:0] match;
  logic [4:0] alarm_en;
  logic       stop;
  logic       snooze;
  logic [4:0] beeping;
  logic [4:0] auto_rst;
  logic [2:0] active_id;
  logic       ringing_any;

  modport master (
    output tick_1s, match, alarm_en, stop, snooze,
    input  beeping, auto_rst, active_id, ringing_any
  );

  modport slave (
    input  tick_1s, match, alarm_en, stop, snooze,
    output beeping, auto_rst, active_id, ringing_any
  );
endinterface

// File: rtl/alarm_beep_ctrl.sv
// Five independent alarm channels (IDLE/RING/SNOOZE) with ring timeout and
// limited snoozes. Define BEEP_PATTERN_EN for a 1 s on / 1 s off beep in RING.
module alarm_beep_ctrl #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input logic               clk,
  input logic               reset,
  alarm_beep_ctrl_if.slave  bus
);

  localparam int RING_W = ($clog2(RING_SECONDS) > 6) ? $clog2(RING_SECONDS) : 6;
  localparam int SNZ_W  = ($clog2(SNOOZE_SECONDS) > 9) ? $clog2(SNOOZE_SECONDS) : 9;
  localparam int SC_W   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t            state_q    [5];
  state_t            state_d    [5];
  logic [RING_W-1:0] ring_cnt_q [5];
  logic [RING_W-1:0] ring_cnt_d [5];
  logic [SNZ_W-1:0]  snz_tmr_q  [5];
  logic [SNZ_W-1:0]  snz_tmr_d  [5];
  logic [SC_W-1:0]   snz_num_q  [5];
  logic [SC_W-1:0]   snz_num_d  [5];

  logic [4:0] match_q;
  logic       armed;
  logic [4:0] rise;
  logic [4:0] beep_q, beep_d;
  logic [4:0] auto_q, auto_d;
  logic [2:0] active_q, active_d;
  logic       ringing_q, ringing_d;

  // The first sample after reset only loads match_q, so a match already high
  // at release is never mistaken for a rising edge.
  assign rise = armed ? (bus.match & ~match_q) : 5'b0;

  always_comb begin
    active_d  = 3'd7;
    ringing_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      state_d[i]    = state_q[i];
      ring_cnt_d[i] = ring_cnt_q[i];
      snz_tmr_d[i]  = snz_tmr_q[i];
      snz_num_d[i]  = snz_num_q[i];
      beep_d[i]     = beep_q[i];
      auto_d[i]     = 1'b0;
      if (!bus.alarm_en[i]) begin
        state_d[i] = IDLE;
        beep_d[i]  = 1'b0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              state_d[i]    = RING;
              ring_cnt_d[i] = '0;
              snz_num_d[i]  = '0;
              beep_d[i]     = 1'b1;
            end
          end
          RING: begin
            // Stop beats snooze and timeout; an exhausted snooze acts as stop.
            if (bus.stop || (bus.snooze && (snz_num_q[i] >= SC_W'(MAX_SNOOZE)))) begin
              state_d[i] = IDLE;
              beep_d[i]  = 1'b0;
            end else if (bus.snooze) begin
              state_d[i]   = SNOOZE;
              snz_num_d[i] = snz_num_q[i] + 1'b1;
              snz_tmr_d[i] = '0;
              beep_d[i]    = 1'b0;
            end else if (bus.tick_1s) begin
              if (ring_cnt_q[i] == RING_W'(RING_SECONDS - 1)) begin
                state_d[i] = IDLE;
                auto_d[i]  = 1'b1;
                beep_d[i]  = 1'b0;
              end else begin
                ring_cnt_d[i] = ring_cnt_q[i] + 1'b1;
`ifdef BEEP_PATTERN_EN
                beep_d[i] = ~beep_q[i];
`else
                beep_d[i] = 1'b1;
`endif
              end
            end
          end
          SNOOZE: begin
            if (bus.stop) begin
              state_d[i] = IDLE;
            end else if (bus.tick_1s) begin
              if (snz_tmr_q[i] == SNZ_W'(SNOOZE_SECONDS - 1)) begin
                state_d[i]    = RING;
                ring_cnt_d[i] = '0;
                beep_d[i]     = 1'b1;
              end else begin
                snz_tmr_d[i] = snz_tmr_q[i] + 1'b1;
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
            beep_d[i]  = 1'b0;
          end
        endcase
      end
    end
    for (int i = 4; i >= 0; i--) begin
      if (state_d[i] == RING) begin
        active_d  = 3'(i);
        ringing_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i]    <= IDLE;
        ring_cnt_q[i] <= '0;
        snz_tmr_q[i]  <= '0;
        snz_num_q[i]  <= '0;
      end
      match_q   <= 5'b0;
      armed     <= 1'b0;
      beep_q    <= 5'b0;
      auto_q    <= 5'b0;
      active_q  <= 3'd7;
      ringing_q <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i]    <= state_d[i];
        ring_cnt_q[i] <= ring_cnt_d[i];
        snz_tmr_q[i]  <= snz_tmr_d[i];
        snz_num_q[i]  <= snz_num_d[i];
      end
      match_q   <= bus.match;
      armed     <= 1'b1;
      beep_q    <= beep_d;
      auto_q    <= auto_d;
      active_q  <= active_d;
      ringing_q <= ringing_d;
    end
  end

  assign bus.beeping     = beep_q;
  assign bus.auto_rst    = auto_q;
  assign bus.active_id   = active_q;
  assign bus.ringing_any = ringing_q;

endmodule

// File: tb/tb_alarm_beep_ctrl.sv
// Self-checking bench for alarm_beep_ctrl: directed scenarios plus random
// stimulus, all compared every cycle against a per-channel behavioural model.
module tb_alarm_beep_ctrl;

  localparam int RING_S  = 60;
  localparam int SNZ_S   = 300;
  localparam int MAX_SN  = 3;
  localparam int M_IDLE  = 0;
  localparam int M_RING  = 1;
  localparam int M_SNZ   = 2;
`ifdef BEEP_PATTERN_EN
  localparam bit PATTERN = 1'b1;
`else
  localparam bit PATTERN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alarm_beep_ctrl_if bus ();

  alarm_beep_ctrl #(
    .RING_SECONDS  (RING_S),
    .SNOOZE_SECONDS(SNZ_S),
    .MAX_SNOOZE    (MAX_SN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad = 0;
  int auto_seen = 0;

  // Model: mode per channel, ticks spent ringing/snoozing, snoozes used.
  int m_mode [5];
  int m_rung [5];
  int m_slept[5];
  int m_used [5];
  bit m_prev [5];
  bit m_auto [5];
  bit m_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic [4:0] m, input logic [4:0] en,
                               input logic sp, input logic sn);
    @(negedge clk);
    bus.tick_1s  = tick;
    bus.match    = m;
    bus.alarm_en = en;
    bus.stop     = sp;
    bus.snooze   = sn;
    @(posedge clk);
    #2;
  endtask

  task automatic tick_n(input int n, input logic [4:0] m, input logic [4:0] en);
    repeat (n) begin
      applyStimulus(1'b0, m, en, 1'b0, 1'b0);
      applyStimulus(1'b1, m, en, 1'b0, 1'b0);
    end
  endtask

  task automatic model_step();
    bit rise;
    if (!reset) begin
      for (int c = 0; c < 5; c++) begin
        m_mode[c] = M_IDLE; m_rung[c] = 0; m_slept[c] = 0; m_used[c] = 0;
        m_prev[c] = 1'b0; m_auto[c] = 1'b0;
      end
      m_valid = 1'b0;
      return;
    end
    for (int c = 0; c < 5; c++) begin
      rise = m_valid && bus.match[c] && !m_prev[c];
      m_auto[c] = 1'b0;
      if (!bus.alarm_en[c]) m_mode[c] = M_IDLE;
      else if (m_mode[c] == M_IDLE) begin
        if (rise) begin m_mode[c] = M_RING; m_rung[c] = 0; m_used[c] = 0; end
      end else if (m_mode[c] == M_RING) begin
        if (bus.stop) m_mode[c] = M_IDLE;
        else if (bus.snooze) begin
          if (m_used[c] == MAX_SN) m_mode[c] = M_IDLE;
          else begin m_mode[c] = M_SNZ; m_used[c]++; m_slept[c] = 0; end
        end else if (bus.tick_1s) begin
          if (m_rung[c] + 1 == RING_S) begin m_mode[c] = M_IDLE; m_auto[c] = 1'b1; end
          else m_rung[c]++;
        end
      end else begin
        if (bus.stop) m_mode[c] = M_IDLE;
        else if (bus.tick_1s) begin
          if (m_slept[c] + 1 == SNZ_S) begin m_mode[c] = M_RING; m_rung[c] = 0; end
          else m_slept[c]++;
        end
      end
      m_prev[c] = bus.match[c];
    end
    m_valid = 1'b1;
  endtask

  // Model steps on every rising edge; outputs are compared 1 time unit later.
  initial begin
    logic [4:0] exp_beep, exp_auto;
    logic [2:0] exp_id;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      exp_beep = '0; exp_auto = '0; exp_id = 3'd7;
      for (int c = 4; c >= 0; c--) begin
        exp_auto[c] = m_auto[c];
        if (m_mode[c] == M_RING) begin
          exp_beep[c] = !PATTERN || (m_rung[c] % 2 == 0);
          exp_id = 3'(c);
        end
      end
      checkOutput("beeping", bus.beeping, exp_beep);
      checkOutput("auto_rst", bus.auto_rst, exp_auto);
      checkOutput("active_id", bus.active_id, exp_id);
      checkOutput("ringing_any", bus.ringing_any, exp_id != 3'd7);
      auto_seen += $countones(bus.auto_rst);
    end
  end

  initial begin
    int a0;
    logic [4:0] rm, ren;
    bus.tick_1s = 0; bus.match = 0; bus.alarm_en = 0; bus.stop = 0; bus.snooze = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_beeping", bus.beeping, 5'b0);
    checkOutput("rst_auto", bus.auto_rst, 5'b0);
    checkOutput("rst_active_id", bus.active_id, 3'd7);
    checkOutput("rst_ringing", bus.ringing_any, 1'b0);

    // Match already high at reset release must not ring.
    bus.match = 5'b00001; bus.alarm_en = 5'b00001; reset = 1'b1;
    repeat (3) applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    checkOutput("no_trig_after_rst", bus.beeping[0], 1'b0);

    $display("[TB] basic ring and timeout on ch0");
    applyStimulus(1'b0, 5'b00000, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    checkOutput("ring_entry", bus.beeping[0], 1'b1);
    checkOutput("ring_entry_id", bus.active_id, 3'd0);
    for (int k = 1; k < 4; k++) begin
      tick_n(1, 5'b00001, 5'b00001);
      checkOutput("beep_pattern", bus.beeping[0], PATTERN ? logic'(k % 2 == 0) : 1'b1);
    end
    a0 = auto_seen;
    tick_n(RING_S - 4, 5'b00001, 5'b00001);
    checkOutput("ring_before_timeout", bus.ringing_any, 1'b1);
    tick_n(1, 5'b00001, 5'b00001);
    checkOutput("timeout_pulse", bus.auto_rst, 5'b00001);
    applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    checkOutput("timeout_pulse_end", bus.auto_rst, 5'b00000);
    checkOutput("timeout_quiet", bus.beeping[0], 1'b0);
    checkOutput("timeout_once", auto_seen - a0, 1);

    $display("[TB] snooze cycle on ch0");
    applyStimulus(1'b0, 5'b00000, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    a0 = auto_seen;
    for (int s = 0; s < MAX_SN; s++) begin
      applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b1);
      checkOutput("snooze_quiet", bus.beeping[0], 1'b0);
      tick_n(SNZ_S - 1, 5'b00001, 5'b00001);
      checkOutput("snooze_still", bus.ringing_any, 1'b0);
      tick_n(1, 5'b00001, 5'b00001);
      checkOutput("snooze_wake", bus.beeping[0], 1'b1);
    end
    applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b1);
    tick_n(SNZ_S, 5'b00001, 5'b00001);
    checkOutput("fourth_snooze_stops", bus.ringing_any, 1'b0);
    checkOutput("fourth_snooze_no_auto", auto_seen - a0, 0);

    $display("[TB] stop and snooze together on ch1 and ch3");
    applyStimulus(1'b0, 5'b00000, 5'b01010, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b01010, 5'b01010, 1'b0, 1'b0);
    checkOutput("two_ring_id", bus.active_id, 3'd1);
    checkOutput("two_ring_beep", bus.beeping, 5'b01010);
    applyStimulus(1'b0, 5'b01010, 5'b01010, 1'b1, 1'b1);
    checkOutput("stop_wins_id", bus.active_id, 3'd7);
    checkOutput("stop_wins_any", bus.ringing_any, 1'b0);

    $display("[TB] enable drop on ch2");
    applyStimulus(1'b0, 5'b00000, 5'b00100, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0);
    checkOutput("ch2_ring", bus.active_id, 3'd2);
    applyStimulus(1'b0, 5'b00100, 5'b00000, 1'b0, 1'b0);
    checkOutput("en_drop_quiet", bus.beeping, 5'b0);
    checkOutput("en_drop_no_auto", bus.auto_rst, 5'b0);
    repeat (3) applyStimulus(1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0);
    checkOutput("reenable_no_retrigger", bus.beeping[2], 1'b0);
    applyStimulus(1'b0, 5'b00000, 5'b00100, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00100, 5'b00100, 1'b0, 1'b0);
    checkOutput("reenable_new_rise", bus.beeping[2], 1'b1);

    $display("[TB] async reset mid ring");
    applyStimulus(1'b0, 5'b00000, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    tick_n(30, 5'b00001, 5'b00001);
    a0 = auto_seen;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_beep", bus.beeping, 5'b0);
    checkOutput("async_rst_id", bus.active_id, 3'd7);
    checkOutput("async_rst_any", bus.ringing_any, 1'b0);
    applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) applyStimulus(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    checkOutput("rst_release_no_trig", bus.beeping[0], 1'b0);
    checkOutput("rst_no_auto", auto_seen - a0, 0);

    $display("[TB] random stimulus");
    rm = 5'b00001; ren = 5'b11111;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 5; c++) begin
        if ($urandom_range(0, 39) == 0) rm[c] = ~rm[c];
        if ($urandom_range(0, 299) == 0) ren[c] = ~ren[c];
      end
      applyStimulus(logic'($urandom_range(0, 2) == 0), rm, ren,
                    logic'($urandom_range(0, 249) == 0), logic'($urandom_range(0, 119) == 0));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
